// File: rtl/comp_bist_pkg.sv
// Shared types and golden truth table for the comp_bist self-test engine.
package comp_bist_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned NUM_VEC = 4;

  // Index is {a,b}; result is {gt,eq,lt}.
  function automatic logic [2:0] exp_out(input logic [1:0] idx);
    logic [2:0] r;
    case (idx)
      2'b00:   r = 3'b010;
      2'b01:   r = 3'b001;
      2'b10:   r = 3'b100;
      default: r = 3'b010;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comp_ref.sv
// Combinational golden 1-bit magnitude comparator used as the BIST reference.
module comp_ref
  import comp_bist_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output logic gt_o,
  output logic eq_o,
  output logic lt_o
);

  assign {gt_o, eq_o, lt_o} = exp_out({a_i, b_i});

endmodule

// File: rtl/comp_bist.sv
// Stimulus/check engine for the 1-bit comparator: sweeps all vectors, counts mismatches.
// Optional first-failure capture ports enabled by defining COMP_BIST_LOG_EN.
module comp_bist
  import comp_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PASSES = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       vec_idx,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y1,
  input  logic             dut_y2,
  input  logic             dut_y3
`ifdef COMP_BIST_LOG_EN
  ,
  output logic             fail_valid,
  output logic [4:0]       fail_vec
`endif
);

  localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [1:0]       ab_q, ab_d;
  logic [ERR_W-1:0] err_q, err_d, err_sat;
  logic             pass_q, pass_d;
  logic             g_gt, g_eq, g_lt;
  logic             mismatch;
  logic             start_acc;

  comp_ref u_ref (
    .a_i  (vec_q[1]),
    .b_i  (vec_q[0]),
    .gt_o (g_gt),
    .eq_o (g_eq),
    .lt_o (g_lt)
  );

  // Golden is always one-hot, so any non-one-hot response compares unequal.
  assign mismatch  = {dut_y1, dut_y2, dut_y3} != {g_gt, g_eq, g_lt};
  assign err_sat   = (err_q == '1) ? err_q : err_q + ERR_W'(1);
  assign start_acc = (state_q == IDLE) && start;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    vec_d    = vec_q;
    ab_d     = ab_q;
    err_d    = err_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          pcnt_d  = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        ab_d     = vec_q;
        settle_d = SW'(SETTLE);
        state_d  = (SETTLE == 0) ? SAMPLE : WAIT;
      end
      WAIT: begin
        settle_d = settle_q - SW'(1);
        if (settle_q <= SW'(1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) err_d = err_sat;
        vec_d   = vec_q + 2'd1;
        state_d = DRIVE;
        if (vec_q == 2'(NUM_VEC - 1)) begin
          pcnt_d = pcnt_q + PW'(1);
          if (pcnt_q == PW'(PASSES - 1)) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      pcnt_q   <= '0;
      vec_q    <= '0;
      ab_q     <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      vec_q    <= vec_d;
      ab_q     <= ab_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
    end
  end

  assign busy    = (state_q == DRIVE) || (state_q == WAIT) || (state_q == SAMPLE);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_idx = vec_q;
  assign dut_a   = ab_q[1];
  assign dut_b   = ab_q[0];

`ifdef COMP_BIST_LOG_EN
  logic       fv_q;
  logic [4:0] fvec_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      fv_q   <= 1'b0;
      fvec_q <= '0;
    end else if ((state_q == SAMPLE) && mismatch && !fv_q) begin
      fv_q   <= 1'b1;
      fvec_q <= {ab_q, dut_y1, dut_y2, dut_y3};
    end
  end

  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
